// File: rtl/generador_secuencia.sv
// rtl/generador_secuencia.sv - serial MSB-first pattern transmitter with repeat count and idle gaps
module generador_secuencia #(
    parameter int N_BITS     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] patron,
    input  logic [3:0]        reps,
    output logic              w,
    output logic              busy,
    output logic              done,
    output logic              q1,
    output logic              q0
);
    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Encoding is visible on q1/q0, so it must stay fixed.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            state, state_n;
    logic [N_BITS-1:0] pat_r, pat_n;
    logic [N_BITS-1:0] sh, sh_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [3:0]        rep_cnt, rep_n;
    logic [GW-1:0]     gap_cnt, gap_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pat_r   <= '0;
            sh      <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            pat_r   <= pat_n;
            sh      <= sh_n;
            bit_cnt <= bit_n;
            rep_cnt <= rep_n;
            gap_cnt <= gap_n;
        end
    end

    always_comb begin
        state_n = state;
        pat_n   = pat_r;
        sh_n    = sh;
        bit_n   = bit_cnt;
        rep_n   = rep_cnt;
        gap_n   = gap_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    pat_n   = patron;
                    sh_n    = patron;
                    bit_n   = BIT_LAST;
                    rep_n   = reps;
                    state_n = (reps != 4'd0) ? SEND : DONE;
                end
            end
            SEND: begin
                sh_n  = sh << 1;
                bit_n = bit_cnt - 1'b1;
                if (bit_cnt == '0) begin
                    if (rep_cnt <= 4'd1) begin
                        state_n = DONE;
                    end else begin
                        rep_n = rep_cnt - 4'd1;
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                            gap_n   = GAP_LAST;
                        end else begin
                            sh_n  = pat_r;
                            bit_n = BIT_LAST;
                        end
                    end
                end
            end
            GAP: begin
                gap_n = gap_cnt - 1'b1;
                if (gap_cnt == '0) begin
                    sh_n    = pat_r;
                    bit_n   = BIT_LAST;
                    state_n = SEND;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign q1   = state[1];
    assign q0   = state[0];
    assign w    = (state == SEND) & sh[N_BITS-1];
    assign busy = (state == SEND) | (state == GAP);
    assign done = (state == DONE);
endmodule

// File: tb/tb_generador_secuencia.sv
// tb/tb_generador_secuencia.sv - random and directed checks against a job-queue reference model
module tb_generador_secuencia;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] patron;
    logic [3:0] reps;
    logic       w_a, busy_a, done_a, q1_a, q0_a;
    logic       w_b, busy_b, done_b, q1_b, q0_b;
    logic [4:0] obs_a, obs_b, ea, eb;
    logic [4:0] exp_a[$];
    logic [4:0] exp_b[$];
    int         vectors = 0;
    int         errors  = 0;

    generador_secuencia dut_a (
        .clk(clk), .rst(rst), .start(start), .patron(patron), .reps(reps),
        .w(w_a), .busy(busy_a), .done(done_a), .q1(q1_a), .q0(q0_a)
    );

    generador_secuencia #(.N_BITS(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .patron(patron), .reps(reps),
        .w(w_b), .busy(busy_b), .done(done_b), .q1(q1_b), .q0(q0_b)
    );

    assign obs_a = {w_a, busy_a, done_a, q1_a, q0_a};
    assign obs_b = {w_b, busy_b, done_b, q1_b, q0_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each job is expanded into its full per-cycle output list {w,busy,done,q1,q0}.
    task automatic push_job(input int which, input logic [3:0] pat, input logic [3:0] n);
        int gap;
        logic [4:0] job[$];
        gap = (which == 0) ? 1 : 0;
        for (int r = 0; r < int'(n); r++) begin
            for (int i = 3; i >= 0; i--) job.push_back({pat[i], 1'b1, 1'b0, 2'b01});
            if (r < int'(n) - 1)
                for (int g = 0; g < gap; g++) job.push_back(5'b01010);
        end
        job.push_back(5'b00111);
        foreach (job[k]) begin
            if (which == 0) exp_a.push_back(job[k]);
            else            exp_b.push_back(job[k]);
        end
    endtask

    task automatic tick(output logic [4:0] xa, output logic [4:0] xb);
        @(posedge clk);
        if (rst) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (exp_a.size() == 0) begin
                if (start) push_job(0, patron, reps);
            end else void'(exp_a.pop_front());
            if (exp_b.size() == 0) begin
                if (start) push_job(1, patron, reps);
            end else void'(exp_b.pop_front());
        end
        @(negedge clk);
        xa = (exp_a.size() != 0) ? exp_a[0] : 5'b0;
        xb = (exp_b.size() != 0) ? exp_b[0] : 5'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (obs_a !== 5'b0) begin errors++; $display("FAIL reset_a got %b want 00000", obs_a); end
        vectors++; if (obs_b !== 5'b0) begin errors++; $display("FAIL reset_b got %b want 00000", obs_b); end
        rst = 1'b0;
        patron = 4'b1011; reps = 4'd3; start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(ea, eb);
            start = 1'b0;
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL pre_rst_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL pre_rst_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        #2 rst = 1'b1;
        #1;
        vectors++; if (obs_a !== 5'b0) begin errors++; $display("FAIL async_rst_a got %b want 00000", obs_a); end
        vectors++; if (obs_b !== 5'b0) begin errors++; $display("FAIL async_rst_b got %b want 00000", obs_b); end
        for (int c = 0; c < 3; c++) begin
            tick(ea, eb);
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL in_rst_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL in_rst_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        rst = 1'b0;
        patron = 4'($urandom); reps = 4'd2; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(ea, eb);
            start = 1'b0;
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL post_rst_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL post_rst_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
    endtask

    task automatic test_single();
        int nbusy = 0;
        int ndone = 0;
        patron = 4'b1011; reps = 4'd1; start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(ea, eb);
            start = 1'b0;
            nbusy += int'(busy_a);
            ndone += int'(done_a);
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL single_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL single_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        vectors++; if (nbusy != 4 || ndone != 1) begin errors++; $display("FAIL single_counts busy=%0d done=%0d want 4/1", nbusy, ndone); end
    endtask

    task automatic test_gap();
        logic [8:0] ws = '0;
        logic [1:0] gq = 2'b00;
        patron = 4'b1001; reps = 4'd2; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(ea, eb);
            start = 1'b0;
            if (c < 9) ws = {ws[7:0], w_a};
            if (c == 4) gq = {q1_a, q0_a};
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL gap_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL gap_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        vectors++; if (ws !== 9'b100101001 || gq !== 2'b10) begin errors++; $display("FAIL gap_stream got %b q=%b want 100101001 q=10", ws, gq); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ws = '0;
        int nbusy = 0;
        patron = 4'b1100; reps = 4'd3; start = 1'b1;
        for (int c = 0; c < 17; c++) begin
            tick(ea, eb);
            start = 1'b0;
            if (c < 12) ws = {ws[10:0], w_b};
            nbusy += int'(busy_b);
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL b2b_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL b2b_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        vectors++; if (ws !== 12'b110011001100 || nbusy != 12) begin errors++; $display("FAIL b2b_stream got %b busy=%0d want 110011001100 busy=12", ws, nbusy); end
    endtask

    task automatic test_empty();
        logic d0 = 1'b0;
        int nbusy = 0;
        patron = 4'b1111; reps = 4'd0; start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(ea, eb);
            start = 1'b0;
            if (c == 0) d0 = done_a;
            nbusy += int'(busy_a) + int'(w_a);
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL empty_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL empty_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        vectors++; if (d0 !== 1'b1 || nbusy != 0) begin errors++; $display("FAIL empty_done done=%b busy_or_w=%0d want 1/0", d0, nbusy); end
    endtask

    task automatic test_ignore_and_hold();
        logic [8:0] ws = '0;
        logic [1:0] q5 = 2'b00;
        logic [1:0] q6 = 2'b00;
        patron = 4'b1011; reps = 4'd2; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(ea, eb);
            if (c < 9) ws = {ws[7:0], w_a};
            patron = 4'($urandom);
            reps   = 4'($urandom);
            start  = (exp_a.size() != 0 && exp_b.size() != 0) ? 1'($urandom) : 1'b0;
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL ignore_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL ignore_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        vectors++; if (ws !== 9'b101101011) begin errors++; $display("FAIL ignore_stream got %b want 101101011", ws); end
        start = 1'b0;
        repeat (4) tick(ea, eb);
        patron = 4'b1100; reps = 4'd1; start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick(ea, eb);
            if (c == 5) q5 = {q1_a, q0_a};
            if (c == 6) q6 = {q1_a, q0_a};
            if (c == 13) start = 1'b0;
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL hold_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL hold_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        vectors++; if (q5 !== 2'b00 || q6 !== 2'b01) begin errors++; $display("FAIL hold_spacing q5=%b q6=%b want 00/01", q5, q6); end
        repeat (8) tick(ea, eb);
    endtask

    task automatic test_random();
        for (int c = 0; c < 120; c++) begin
            start  = ($urandom_range(0, 3) == 0);
            patron = 4'($urandom);
            reps   = 4'($urandom_range(0, 3));
            tick(ea, eb);
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL random_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL random_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(ea, eb);
            vectors++; if (obs_a !== ea) begin errors++; $display("FAIL drain_a cyc %0d got %b want %b", c, obs_a, ea); end
            vectors++; if (obs_b !== eb) begin errors++; $display("FAIL drain_b cyc %0d got %b want %b", c, obs_b, eb); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; patron = '0; reps = '0;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_empty();
        test_ignore_and_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
